eeprom_cmd_sequencer: RTL and testbench
=======================================

Name: eeprom_cmd_sequencer

Overview:
Upstream command front-end for eeprom_top. Buffers EEPROM read/write requests in a small FIFO and issues them one at a time over eeprom_top's newd/wr/addr/wdata interface. Waits for each done, then returns a response with read data over a valid/ready channel. Lets host logic queue transactions without tracking I2C timing.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of 2, minimum 2.
NEWD_CYCLES, 2, clock cycles newd is held high per issued command; minimum 1.
TIMEOUT_CYCLES, 100000, maximum cycles to wait for done before flagging an error (only with SEQ_TIMEOUT_EN).

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  host command valid
cmd_ready  output  1  FIFO not full
cmd_wr  input  1  1 = write, 0 = read
cmd_addr  input  7  EEPROM address
cmd_wdata  input  8  write data; ignored for reads
rsp_valid  output  1  response valid
rsp_ready  input  1  host accepts response
rsp_wr  output  1  op type of the completed command
rsp_addr  output  7  address of the completed command
rsp_rdata  output  8  read data; 0 for writes
rsp_err  output  1  done timeout (0 when feature absent)
newd  output  1  to eeprom_top: start request
wr  output  1  to eeprom_top
addr  output  7  to eeprom_top
wdata  output  8  to eeprom_top
done  input  1  from eeprom_top: transaction complete
rdata  input  8  from eeprom_top: read data
busy  output  1  FSM not IDLE or FIFO non-empty
fifo_count  output  $clog2(FIFO_DEPTH)+1  entries held

Behaviour:
- Reset (sync, rst=1 at clk edge): FIFO empty, fifo_count=0, cmd_ready=1, FSM=IDLE, newd=0, wr=0, addr=0, wdata=0, rsp_valid=0, rsp_wr=0, rsp_addr=0, rsp_rdata=0, rsp_err=0, busy=0, done_q=0. Reset mid-transaction abandons the operation; no response is produced.
- FIFO: push when cmd_valid & cmd_ready. Pop on the IDLE->ISSUE transition. Push and pop in the same cycle are both allowed, and the count is unchanged. Full: cmd_ready=0 and cmd_valid is ignored. Pointers wrap modulo FIFO_DEPTH.
- done_q registers done every cycle. done_rise = done & ~done_q.
- FSM:
  - IDLE: if FIFO non-empty and rsp_valid=0, pop the head, latch wr/addr/wdata into the output registers, set newd=1, load the counter with NEWD_CYCLES-1, go to ISSUE. Latency from the first push into an empty FIFO to newd=1 is 2 cycles.
  - ISSUE: hold newd=1 and decrement the counter. At 0, drive newd=0 next cycle, clear the timeout counter, go to WAIT_DONE. wr/addr/wdata stay stable until the response is captured.
  - WAIT_DONE: on done_rise, capture rsp_rdata = wr ? 0 : rdata, rsp_wr, rsp_addr, rsp_err=0, set rsp_valid=1, go to RESP. A done level already high on entry without a rising edge is ignored.
  - RESP: hold the response until rsp_valid & rsp_ready, then clear rsp_valid and go to IDLE. The next command issues no earlier than the cycle after acceptance.
- Only one transaction is outstanding on eeprom_top at any time.
- busy = (state!=IDLE) | (fifo_count!=0).

Optional Feature:
SEQ_TIMEOUT_EN:
- Defined: a 32-bit counter increments each cycle in WAIT_DONE. On reaching TIMEOUT_CYCLES without done_rise, go to RESP with rsp_err=1, rsp_rdata=0 and the latched rsp_wr/rsp_addr. done_rise on the same cycle as the timeout takes priority (rsp_err=0).
- Undefined: no counter. WAIT_DONE waits indefinitely and rsp_err is tied 0.

Test Plan:
- Reset then single write addr=0x50 wdata=0xAA -> newd high exactly 2 cycles with wr=1, addr=0x50, wdata=0xAA; after done pulse, rsp_valid=1, rsp_wr=1, rsp_addr=0x50, rsp_rdata=0x00, rsp_err=0.
- Read addr=0x50 with model returning 0xAA -> rsp_rdata=0xAA, rsp_wr=0; second newd only after rsp_ready accepted.
- Push 5 commands back-to-back with FIFO_DEPTH=4 and the EEPROM busy -> cmd_ready=0 once 4 are held; all commands complete in push order with matching rsp_addr.
- Hold rsp_ready=0 for 50 cycles after a response -> rsp fields stable, newd stays 0, fifo_count unchanged; acceptance releases the next issue.
- Assert rst during WAIT_DONE with 2 queued commands -> next cycle fifo_count=0, newd=0, rsp_valid=0; a later done pulse produces no response.
- With SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=100, never assert done -> rsp_valid=1, rsp_err=1 exactly 100 cycles after WAIT_DONE entry; without the macro, rsp_valid stays 0.

Source files
------------

// File: rtl/eeprom_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : eeprom_cmd_sequencer
// Purpose  : Command front-end for eeprom_top. Queues host read/write
//            requests in a small FIFO. It issues them one at a time over
//            eeprom_top's newd/wr/addr/wdata handshake and waits for done.
//            It then returns the result on a valid/ready response channel.
// Ports    :
//   clk, rst                  - clock, synchronous active-high reset
//   cmd_valid/ready/wr/addr/wdata   - host command channel (FIFO push side)
//   rsp_valid/ready/wr/addr/rdata/err - host response channel
//   newd, wr, addr, wdata     - request to eeprom_top
//   done, rdata               - completion and read data from eeprom_top
//   busy, fifo_count          - status
// Options  : define SEQ_TIMEOUT_EN to bound the wait for done to
//            TIMEOUT_CYCLES. A timed-out command responds with rsp_err=1.
//            Without the macro there is no counter and rsp_err stays 0.
// Revision : 1.0 - initial release
// ============================================================================
module eeprom_cmd_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int NEWD_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                          clk,
    input  logic                          rst,
    // host command channel
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_wr,
    input  logic [6:0]                    cmd_addr,
    input  logic [7:0]                    cmd_wdata,
    // host response channel
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic                          rsp_wr,
    output logic [6:0]                    rsp_addr,
    output logic [7:0]                    rsp_rdata,
    output logic                          rsp_err,
    // eeprom_top request interface
    output logic                          newd,
    output logic                          wr,
    output logic [6:0]                    addr,
    output logic [7:0]                    wdata,
    input  logic                          done,
    input  logic [7:0]                    rdata,
    // status
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = (NEWD_CYCLES > 1) ? $clog2(NEWD_CYCLES) : 1;

    localparam logic [c_ptr_w:0]   c_full      = (c_ptr_w + 1)'(FIFO_DEPTH);
    localparam logic [c_ptr_w:0]   c_count_one = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one   = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_newd_load = c_cnt_w'(NEWD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_newd_one  = c_cnt_w'(1);

    // Reject illegal configurations at elaboration time.
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
        (NEWD_CYCLES < 1) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
        $error("eeprom_cmd_sequencer: illegal parameter value");
    end

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RESP      = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic                 r_mem_wr    [FIFO_DEPTH];
    logic [6:0]           r_mem_addr  [FIFO_DEPTH];
    logic [7:0]           r_mem_wdata [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w:0]     r_count;

    state_t               r_state;
    logic                 r_rsp_valid;
    logic                 w_push;
    logic                 w_pop;

    assign cmd_ready = (r_count != c_full);
    assign w_push    = cmd_valid & cmd_ready;
    // The head is consumed on the same edge the FSM leaves IDLE.
    assign w_pop     = (r_state == ST_IDLE) && (r_count != '0) && !r_rsp_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_count_one;
                2'b01:   r_count <= r_count - c_count_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; only entries between the pointers are read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_wr[r_wr_ptr]    <= cmd_wr;
            r_mem_addr[r_wr_ptr]  <= cmd_addr;
            r_mem_wdata[r_wr_ptr] <= cmd_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    logic                 r_done_q;
    logic                 w_done_rise;
    logic [c_cnt_w-1:0]   r_newd_cnt;
    logic                 r_newd;
    logic                 r_wr;
    logic [6:0]           r_addr;
    logic [7:0]           r_wdata;
    logic                 r_rsp_wr;
    logic [6:0]           r_rsp_addr;
    logic [7:0]           r_rsp_rdata;
    logic                 r_rsp_err;

`ifdef SEQ_TIMEOUT_EN
    localparam logic [31:0] c_timeout_last = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0]          r_tcnt;
`endif

    // Only an edge counts: a done level left high from before the request
    // must not complete the new one.
    assign w_done_rise = done & ~r_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_done_q    <= 1'b0;
            r_newd_cnt  <= '0;
            r_newd      <= 1'b0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_wr    <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            r_tcnt      <= '0;
`endif
        end else begin
            r_done_q <= done;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_wr       <= r_mem_wr[r_rd_ptr];
                        r_addr     <= r_mem_addr[r_rd_ptr];
                        r_wdata    <= r_mem_wdata[r_rd_ptr];
                        r_newd     <= 1'b1;
                        r_newd_cnt <= c_newd_load;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (r_newd_cnt == '0) begin
                        r_newd  <= 1'b0;
                        r_state <= ST_WAIT_DONE;
`ifdef SEQ_TIMEOUT_EN
                        r_tcnt  <= '0;
`endif
                    end else begin
                        r_newd_cnt <= r_newd_cnt - c_newd_one;
                    end
                end
                ST_WAIT_DONE: begin
                    // A done edge wins over a simultaneous timeout.
                    if (w_done_rise) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_wr    <= r_wr;
                        r_rsp_addr  <= r_addr;
                        r_rsp_rdata <= r_wr ? 8'h00 : rdata;
                        r_rsp_err   <= 1'b0;
                        r_state     <= ST_RESP;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (r_tcnt == c_timeout_last) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_wr    <= r_wr;
                        r_rsp_addr  <= r_addr;
                        r_rsp_rdata <= 8'h00;
                        r_rsp_err   <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_tcnt <= r_tcnt + 32'd1;
                    end
`endif
                end
                ST_RESP: begin
                    // rsp_valid is always high here.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign newd       = r_newd;
    assign wr         = r_wr;
    assign addr       = r_addr;
    assign wdata      = r_wdata;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_wr     = r_rsp_wr;
    assign rsp_addr   = r_rsp_addr;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_err    = r_rsp_err;
    assign busy       = (r_state != ST_IDLE) || (r_count != '0);
    assign fifo_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_eeprom_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_eeprom_cmd_sequencer
// Purpose  : Self-checking bench for eeprom_cmd_sequencer. It contains an
//            EEPROM behavioural model plus issue and response scoreboards.
//            Define SEQ_TIMEOUT_EN to exercise the timeout variant.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eeprom_cmd_sequencer;

    localparam int FIFO_DEPTH     = 4;
    localparam int NEWD_CYCLES    = 2;
    localparam int TIMEOUT_CYCLES = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_wr;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_wr;
    logic [6:0] rsp_addr;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       newd;
    logic       wr;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       done;
    logic [7:0] rdata;
    logic       busy;
    logic [2:0] fifo_count;

    always #5 clk = ~clk;

    eeprom_cmd_sequencer #(
        .FIFO_DEPTH     (FIFO_DEPTH),
        .NEWD_CYCLES    (NEWD_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_wr     (cmd_wr),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_wr     (rsp_wr),
        .rsp_addr   (rsp_addr),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .newd       (newd),
        .wr         (wr),
        .addr       (addr),
        .wdata      (wdata),
        .done       (done),
        .rdata      (rdata),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic       wr;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        logic       err;
    } txn_t;

    txn_t       iss_q[$];
    txn_t       rsp_q[$];
    logic [7:0] ref_mem [128];
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_add(input logic w, input logic [6:0] a, input logic [7:0] d, input logic e);
        txn_t t;
        t.wr    = w;
        t.addr  = a;
        t.wdata = d;
        t.err   = e;
        if (w) begin
            ref_mem[a] = d;
            t.rdata    = 8'h00;
        end else begin
            t.rdata = e ? 8'h00 : ref_mem[a];
        end
        iss_q.push_back(t);
        rsp_q.push_back(t);
    endtask

    // ------------------------------------------------------------------
    // EEPROM model and monitors (all sampling on the falling edge)
    // ------------------------------------------------------------------
    logic [7:0] ee_mem [128];
    logic       model_done  = 1'b0;
    logic [7:0] model_rdata = 8'h00;
    logic       man_done    = 1'b0;
    bit         model_en    = 1'b1;
    int         model_delay = 4;
    int         pend        = -1;
    int         newd_len    = 0;
    logic       newd_q      = 1'b0;
    bit         outstanding = 1'b0;
    logic       cur_wr;
    logic [6:0] cur_addr;
    logic [7:0] cur_wdata;
    txn_t       mon_t;

    assign done  = model_done | man_done;
    assign rdata = model_rdata;

    always @(negedge clk) begin
        model_done = 1'b0;
        if (rst) begin
            pend        = -1;
            newd_q      = 1'b0;
            newd_len    = 0;
            outstanding = 1'b0;
        end else begin
            // response side
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 0);
                end else begin
                    mon_t = rsp_q.pop_front();
                    check("rsp_wr",    32'(rsp_wr),    32'(mon_t.wr));
                    check("rsp_addr",  32'(rsp_addr),  32'(mon_t.addr));
                    check("rsp_rdata", 32'(rsp_rdata), 32'(mon_t.rdata));
                    check("rsp_err",   32'(rsp_err),   32'(mon_t.err));
                end
                outstanding = 1'b0;
            end
            // issue side
            if (newd && !newd_q) begin
                if (iss_q.size() == 0) begin
                    check("issue_unexpected", 32'(newd), 0);
                end else begin
                    mon_t = iss_q.pop_front();
                    check("issue_wr",    32'(wr),    32'(mon_t.wr));
                    check("issue_addr",  32'(addr),  32'(mon_t.addr));
                    check("issue_wdata", 32'(wdata), 32'(mon_t.wdata));
                end
                check("issue_during_rsp", 32'(rsp_valid), 0);
                check("issue_outstanding", 32'(outstanding), 0);
                outstanding = 1'b1;
                cur_wr      = wr;
                cur_addr    = addr;
                cur_wdata   = wdata;
                newd_len    = 0;
            end
            if (newd) begin
                newd_len++;
            end
            if (!newd && newd_q) begin
                check("newd_width", 32'(newd_len), NEWD_CYCLES);
                if (model_en) begin
                    pend = model_delay;
                end
            end
            // completion
            if (pend == 0) begin
                model_done = 1'b1;
                if (cur_wr) begin
                    ee_mem[cur_addr] = cur_wdata;
                    model_rdata      = 8'h5A;   // garbage: must be ignored on writes
                end else begin
                    model_rdata = ee_mem[cur_addr];
                end
                pend = -1;
            end else if (pend > 0) begin
                pend--;
            end
            newd_q = newd;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic push(input logic w, input logic [6:0] a, input logic [7:0] d, input logic e);
        int tries = 0;
        bit ok    = 1'b0;
        cmd_wr    = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        while (!ok && tries < 500) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                sb_add(w, a, d, e);
            end
            @(posedge clk);
            #1;
            tries++;
        end
        check("push_accept", 32'(ok), 1);
    endtask

    task automatic wait_idle(input string tag);
        int cyc = 0;
        while ((rsp_q.size() != 0 || busy) && cyc < 2000) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        check(tag, 32'(rsp_q.size() == 0 && !busy), 1);
    endtask

    // Returns on the falling edge where newd is first seen low again.
    task automatic wait_newd_fall(input string tag);
        int cyc = 0;
        while (!newd && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        while (newd && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, 32'(cyc < 100), 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        iss_q.delete();
        rsp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        for (int i = 0; i < 128; i++) begin
            ee_mem[i]  = 8'(i * 3 + 1);
            ref_mem[i] = 8'(i * 3 + 1);
        end
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_cmd_ready",  32'(cmd_ready),  1);
        check("rst_fifo_count", 32'(fifo_count), 0);
        check("rst_busy",       32'(busy),       0);
        check("rst_newd",       32'(newd),       0);
        check("rst_wr",         32'(wr),         0);
        check("rst_addr",       32'(addr),       0);
        check("rst_wdata",      32'(wdata),      0);
        check("rst_rsp_valid",  32'(rsp_valid),  0);
        check("rst_rsp_rdata",  32'(rsp_rdata),  0);
        check("rst_rsp_err",    32'(rsp_err),    0);

        // single write: newd appears two cycles after the push
        @(posedge clk);
        #1;
        push(1'b1, 7'h50, 8'hAA, 1'b0);
        cmd_valid = 1'b0;
        check("lat1_newd",  32'(newd),       0);
        check("lat1_count", 32'(fifo_count), 1);
        check("lat1_busy",  32'(busy),       1);
        @(posedge clk);
        #1;
        check("lat2_newd",  32'(newd),       1);
        check("lat2_count", 32'(fifo_count), 0);
        wait_idle("idle_write");

        // read back with response back-pressure for 50 cycles
        rsp_ready = 1'b0;
        push(1'b0, 7'h50, 8'h00, 1'b0);
        push(1'b0, 7'h51, 8'h33, 1'b0);
        cmd_valid = 1'b0;
        begin
            int cyc = 0;
            while (!rsp_valid && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            check("bp_rsp_seen", 32'(rsp_valid), 1);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid),  1);
            check("bp_rsp_wr",    32'(rsp_wr),     32'(rsp_q[0].wr));
            check("bp_rsp_addr",  32'(rsp_addr),   32'(rsp_q[0].addr));
            check("bp_rsp_rdata", 32'(rsp_rdata),  8'hAA);
            check("bp_newd",      32'(newd),       0);
            check("bp_count",     32'(fifo_count), 1);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_idle("idle_backpressure");

        // burst of five into a depth-4 FIFO with a slow EEPROM
        model_delay = 30;
        push(1'b1, 7'h10, 8'h11, 1'b0);
        push(1'b0, 7'h10, 8'h00, 1'b0);
        push(1'b1, 7'h11, 8'h22, 1'b0);
        push(1'b0, 7'h11, 8'h00, 1'b0);
        push(1'b0, 7'h12, 8'h00, 1'b0);
        check("full_count",     32'(fifo_count), 4);
        check("full_cmd_ready", 32'(cmd_ready),  0);
        cmd_addr  = 7'h13;
        cmd_wdata = 8'h99;
        cmd_wr    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("full_ignored", 32'(fifo_count), 4);
        end
        cmd_valid = 1'b0;
        wait_idle("idle_burst");
        model_delay = 4;

        // reset while waiting for done with two commands queued
        model_en = 1'b0;
        push(1'b0, 7'h20, 8'h00, 1'b0);
        push(1'b0, 7'h21, 8'h00, 1'b0);
        push(1'b0, 7'h22, 8'h00, 1'b0);
        cmd_valid = 1'b0;
        wait_newd_fall("mid_wait_reached");
        check("mid_count", 32'(fifo_count), 2);
        do_reset();
        check("mrst_count",     32'(fifo_count), 0);
        check("mrst_newd",      32'(newd),       0);
        check("mrst_rsp_valid", 32'(rsp_valid),  0);
        check("mrst_busy",      32'(busy),       0);
        check("mrst_cmd_ready", 32'(cmd_ready),  1);
        @(posedge clk);
        #1 man_done = 1'b1;
        @(posedge clk);
        #1 man_done = 1'b0;
        repeat (10) @(negedge clk);
        check("late_done_rsp_valid", 32'(rsp_valid), 0);
        check("late_done_newd",      32'(newd),      0);
        @(posedge clk);
        #1;

        // done never arrives
`ifdef SEQ_TIMEOUT_EN
        push(1'b0, 7'h7F, 8'h00, 1'b1);
        cmd_valid = 1'b0;
        wait_newd_fall("to_wait_reached");
        begin
            int cyc = 0;
            while (!rsp_valid && cyc < 300) begin
                @(negedge clk);
                cyc++;
            end
            check("timeout_latency", 32'(cyc), TIMEOUT_CYCLES);
            check("timeout_err",     32'(rsp_err), 1);
        end
        @(posedge clk);
        #1;
        wait_idle("idle_timeout");
`else
        push(1'b0, 7'h7F, 8'h00, 1'b0);
        cmd_valid = 1'b0;
        wait_newd_fall("to_wait_reached");
        repeat (150) @(negedge clk);
        check("no_timeout_rsp_valid", 32'(rsp_valid), 0);
        check("no_timeout_rsp_err",   32'(rsp_err),   0);
        check("no_timeout_busy",      32'(busy),      1);
        do_reset();
`endif
        model_en = 1'b1;

        // recovery: normal traffic after reset
        push(1'b1, 7'h22, 8'h5C, 1'b0);
        push(1'b0, 7'h22, 8'h00, 1'b0);
        cmd_valid = 1'b0;
        wait_idle("idle_recovery");
        check("end_count", 32'(fifo_count), 0);
        check("end_busy",  32'(busy),       0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
